// File: rtl/fft16_ctrl.sv
// 16-point radix-2 DIF FFT controller: buffers one frame, sequences 32 butterflies through an
// external PE in place, then streams the results in natural frequency order.
module fft16_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [2*DATA_W-1:0]   in_data,
  output logic                  busy,
  output logic [2*DATA_W-1:0]   pe_a,
  output logic [2*DATA_W-1:0]   pe_b,
  output logic [2:0]            pe_power,
  output logic                  pe_ab_valid,
  input  logic [2*DATA_W-1:0]   pe_fft_a,
  input  logic [2*DATA_W-1:0]   pe_fft_b,
  input  logic                  pe_valid,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   out_data,
  output logic [3:0]            out_index
);
  localparam int SAMPLE_W = 2*DATA_W;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_OUTPUT} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [1:0]          stage_q, stage_d;
  logic [2:0]          bfly_q, bfly_d;
  logic [SAMPLE_W-1:0] buf_q [16];

  logic [3:0]          top, bot;
  logic [2:0]          power;
  logic                load_we, pe_we;

  function automatic logic [3:0] bitrev4(input logic [3:0] k);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = k[3-i];
    return r;
  endfunction

  // Butterfly addressing: top inserts a 0 at bit (3-stage) of bfly; bot sets that bit.
  always_comb begin
    top   = 4'd0;
    power = 3'd0;
    case (stage_q)
      2'd0: begin top = {1'b0, bfly_q};                 power = bfly_q;               end
      2'd1: begin top = {bfly_q[2], 1'b0, bfly_q[1:0]}; power = {bfly_q[1:0], 1'b0};  end
      2'd2: begin top = {bfly_q[2:1], 1'b0, bfly_q[0]}; power = {bfly_q[0], 2'b00};   end
      default: begin top = {bfly_q, 1'b0};              power = 3'd0;                 end
    endcase
    bot = top | (4'd8 >> stage_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    load_we = 1'b0;
    pe_we   = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (in_valid) begin
          load_we = 1'b1;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = S_ISSUE;
            stage_d = 2'd0;
            bfly_d  = 3'd0;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (pe_valid) begin
          pe_we   = 1'b1;
          bfly_d  = bfly_q + 3'd1;
          state_d = S_ISSUE;
          if (bfly_q == 3'd7) begin
            stage_d = stage_q + 2'd1;
            if (stage_q == 2'd3) begin
              state_d = S_OUTPUT;
              cnt_d   = 4'd0;
            end
          end
        end
      end
      S_OUTPUT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      stage_q <= 2'd0;
      bfly_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
    end
  end

  // Sample buffer carries no reset; every frame overwrites all 16 entries before use.
  always_ff @(posedge clk) begin
    if (load_we) buf_q[cnt_q] <= in_data;
    if (pe_we) begin
      buf_q[top] <= pe_fft_a;
      buf_q[bot] <= pe_fft_b;
    end
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    pe_ab_valid = (state_q == S_ISSUE);
    pe_a        = '0;
    pe_b        = '0;
    pe_power    = 3'd0;
    out_valid   = (state_q == S_OUTPUT);
    out_data    = '0;
    out_index   = 4'd0;
    if (state_q == S_ISSUE) begin
      pe_a     = buf_q[top];
      pe_b     = buf_q[bot];
      pe_power = power;
    end
    if (state_q == S_OUTPUT) begin
      out_data  = buf_q[bitrev4(cnt_q)];
      out_index = cnt_q;
    end
  end

endmodule

// File: tb/tb_fft16_ctrl.sv
// Directed bench for fft16_ctrl with a behavioural PE (butterfly or pass-through, variable latency).
module tb_fft16_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        busy, pe_ab_valid, out_valid;
  logic [31:0] pe_a, pe_b, out_data;
  logic [2:0]  pe_power;
  logic [3:0]  out_index;
  logic [31:0] pe_fft_a = '0, pe_fft_b = '0;
  logic        pe_valid_m = 1'b0, stale_v = 1'b0;
  logic        pe_valid;

  assign pe_valid = pe_valid_m | stale_v;

  fft16_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .busy(busy),
    .pe_a(pe_a), .pe_b(pe_b), .pe_power(pe_power), .pe_ab_valid(pe_ab_valid),
    .pe_fft_a(pe_fft_a), .pe_fft_b(pe_fft_b), .pe_valid(pe_valid),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index)
  );

  initial forever #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int pe_delay = 1;
  bit pe_ident = 1'b0;

  localparam int COS_T [8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
  localparam int SIN_T [8] = '{0, 6270, 11585, 15137, 16384, 15137, 11585, 6270};

  function automatic logic [31:0] bf_top(input logic [31:0] a, input logic [31:0] b);
    logic [15:0] re, im;
    re = a[31:16] + b[31:16];
    im = a[15:0] + b[15:0];
    return {re, im};
  endfunction

  // (a-b) * W16^p with W = cos - j*sin, twiddles in Q14.
  function automatic logic [31:0] bf_bot(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] p);
    int dr, di, re, im;
    dr = int'($signed(a[31:16])) - int'($signed(b[31:16]));
    di = int'($signed(a[15:0])) - int'($signed(b[15:0]));
    re = (dr * COS_T[p] + di * SIN_T[p]) >>> 14;
    im = (di * COS_T[p] - dr * SIN_T[p]) >>> 14;
    return {re[15:0], im[15:0]};
  endfunction

  function automatic logic [3:0] br4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  function automatic logic [31:0] tag(input int i);
    return 32'h5A00_0000 | 32'(i * 17);
  endfunction

  // PE model: samples the issue on the falling edge, answers pe_delay cycles later.
  int          n_issue = 0;
  int          dly_cnt = 0;
  logic [31:0] hold_a = '0, hold_b = '0;
  logic [31:0] log_a [64];
  logic [31:0] log_b [64];
  logic [2:0]  log_p [64];

  always @(negedge clk) begin
    pe_valid_m <= 1'b0;
    if (pe_ab_valid) begin
      log_a[n_issue % 64] <= pe_a;
      log_b[n_issue % 64] <= pe_b;
      log_p[n_issue % 64] <= pe_power;
      n_issue <= n_issue + 1;
      hold_a  <= pe_ident ? pe_a : bf_top(pe_a, pe_b);
      hold_b  <= pe_ident ? pe_b : bf_bot(pe_a, pe_b, pe_power);
      dly_cnt <= pe_delay;
    end else if (dly_cnt != 0) begin
      dly_cnt <= dly_cnt - 1;
      if (dly_cnt == 1) begin
        pe_valid_m <= 1'b1;
        pe_fft_a   <= hold_a;
        pe_fft_b   <= hold_b;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  logic [31:0] frame_x [16];
  logic [31:0] exp_x [16];

  task automatic load_frame();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frame_x[i];
    end
  endtask

  // Waits for the output burst and checks all 16 bins; ends on the falling edge after bin 15.
  task automatic collect(input string name, input int exp_lat, input bit hold);
    int n;
    n = 1;
    @(negedge clk);
    in_valid = hold;
    in_data  = 32'hDEAD_BEEF;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_out_valid"}, 32'(out_valid), 32'd1);
    if (exp_lat > 0) chk({name, "_latency"}, 32'(n), 32'(exp_lat));
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_idx%0d", name, k), 32'(out_index), 32'(k));
      chk($sformatf("%s_bin%0d", name, k), out_data, exp_x[k]);
      chk($sformatf("%s_abv%0d", name, k), 32'(pe_ab_valid), 32'd0);
      @(negedge clk);
    end
    chk({name, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int base, guard;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_abv", 32'(pe_ab_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pe_a", pe_a, 32'd0);
    chk("rst_pe_b", pe_b, 32'd0);
    chk("rst_pe_power", 32'(pe_power), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    rst = 1'b0;

    // Impulse, single-cycle PE.
    for (int i = 0; i < 16; i++) begin
      frame_x[i] = (i == 0) ? {16'd100, 16'd0} : 32'd0;
      exp_x[i]   = {16'd100, 16'd0};
    end
    base = n_issue;
    load_frame();
    collect("impulse", 65, 1'b0);
    chk("impulse_issues", 32'(n_issue - base), 32'd32);

    // DC, PE stalls 3 cycles per butterfly.
    pe_delay = 3;
    for (int i = 0; i < 16; i++) begin
      frame_x[i] = {16'd10, 16'd0};
      exp_x[i]   = (i == 0) ? {16'd160, 16'd0} : 32'd0;
    end
    base = n_issue;
    load_frame();
    collect("dc_stall", 0, 1'b0);
    chk("dc_stall_issues", 32'(n_issue - base), 32'd32);

    // Pass-through PE with tagged samples: exposes issue order and output bit reversal.
    pe_delay = 2;
    pe_ident = 1'b1;
    for (int i = 0; i < 16; i++) begin
      frame_x[i] = tag(i);
      exp_x[i]   = tag(int'(br4(4'(i))));
    end
    base = n_issue;
    load_frame();
    collect("seq", 0, 1'b0);
    chk("seq_issues", 32'(n_issue - base), 32'd32);
    for (int i = 0; i < 32; i++) begin
      int s, b, span, g, j, t, bt, pw;
      s = i / 8;  b = i % 8;
      span = 8 >> s;  g = b / span;  j = b % span;
      t = 2 * span * g + j;  bt = t + span;  pw = (j << s) % 8;
      chk($sformatf("seq_top_i%0d", i), log_a[(base + i) % 64], tag(t));
      chk($sformatf("seq_bot_i%0d", i), log_b[(base + i) % 64], tag(bt));
      chk($sformatf("seq_pow_i%0d", i), 32'(log_p[(base + i) % 64]), 32'(pw));
    end
    pe_ident = 1'b0;
    pe_delay = 1;

    // Reset in stage 2, then a stale PE result while idle.
    for (int i = 0; i < 16; i++) frame_x[i] = {16'd7, 16'd3};
    base = n_issue;
    load_frame();
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while ((n_issue - base) < 17 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("midrst_reached_stage2", 32'((n_issue - base) >= 17), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_abv", 32'(pe_ab_valid), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    stale_v = 1'b1;
    @(negedge clk);
    stale_v = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stale_busy%0d", c), 32'(busy), 32'd0);
      chk($sformatf("stale_abv%0d", c), 32'(pe_ab_valid), 32'd0);
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      frame_x[i] = (i == 0) ? {16'd100, 16'd0} : 32'd0;
      exp_x[i]   = {16'd100, 16'd0};
    end
    load_frame();
    collect("post_rst", 65, 1'b0);

    // in_valid held high through compute and output.
    for (int i = 0; i < 16; i++) begin
      frame_x[i] = {16'd5, 16'd0};
      exp_x[i]   = (i == 0) ? {16'd80, 16'd0} : 32'd0;
    end
    load_frame();
    collect("hold", 65, 1'b1);
    @(negedge clk);
    chk("hold_next_frame_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("final_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
